pim_mac_seq: RTL and testbench

PIM_MAC_SEQ -- requirements
Module: pim_mac_seq

---
 rtl/pim_pkg.sv | 31 +++
 rtl/pim_act_buf.sv | 52 +++++
 rtl/pim_mac_seq.sv | 244 ++++++++++++++++++++++++
 tb/tb_pim_mac_seq.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pim_pkg.sv
// Shared definitions for the PIM MAC sequencer: opcodes, FSM states and
// default array geometry.
package pim_pkg;

    localparam int ROWS_DEF   = 32;
    localparam int PWIDTH_DEF = 32;
    localparam int ABITS_DEF  = 8;
    localparam int SUMW_DEF   = 11;

    typedef enum logic [2:0] {
        OP_READ      = 3'd0,
        OP_WRITE     = 3'd1,
        OP_LOAD_ACT  = 3'd2,
        OP_MAC       = 3'd3,
        OP_CLEAR_ACT = 3'd4,
        OP_ILL5      = 3'd5,
        OP_ILL6      = 3'd6,
        OP_ILL7      = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_MAC_RUN,
        ST_MAC_DRAIN,
        ST_RESP
    } state_e;

endpackage

// File: rtl/pim_act_buf.sv
// Activation buffer: ROWS entries of ABITS bits. Loaded four entries at a
// time from one 32-bit word, cleared in one cycle, and read out one bit-plane
// at a time as the word-line vector for the array.
module pim_act_buf
    import pim_pkg::*;
#(
    parameter int ROWS  = ROWS_DEF,
    parameter int ABITS = ABITS_DEF,
    parameter int PLW   = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_en,
    input  logic [2:0]      load_grp,
    input  logic [31:0]     load_data,
    input  logic            clr_en,
    input  logic [PLW-1:0]  plane_sel,
    output logic [ROWS-1:0] plane_vec
);

    logic [ABITS-1:0] act_q [ROWS];
    logic [ABITS-1:0] act_d [ROWS];

    // Next buffer contents: clear wins, otherwise the selected group of four
    // rows takes one byte each, low byte to the lowest row.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            act_d[r] = act_q[r];
            if (clr_en) begin
                act_d[r] = '0;
            end else if (load_en && ((r / 4) == int'(load_grp))) begin
                act_d[r] = ABITS'(load_data[8*(r%4) +: 8]);
            end
        end
    end

    // Buffer storage; reset empties it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < ROWS; r++) act_q[r] <= '0;
        end else begin
            for (int r = 0; r < ROWS; r++) act_q[r] <= act_d[r];
        end
    end

    // Bit-plane extraction: word line j carries bit plane_sel of entry j.
    always_comb begin
        plane_vec = '0;
        for (int r = 0; r < ROWS; r++) plane_vec[r] = act_q[r][plane_sel];
    end

endmodule

// File: rtl/pim_mac_seq.sv
// PIM MAC sequencer: accepts one CFU command at a time, drives the
// processing-in-memory array (read, write, bit-serial MAC) through registered
// strobes and returns a single response per command.
module pim_mac_seq
    import pim_pkg::*;
#(
    parameter int ROWS   = ROWS_DEF,
    parameter int PWIDTH = PWIDTH_DEF,
    parameter int ABITS  = ABITS_DEF,
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 32,
    parameter int SUMW   = SUMW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_payload_function_id,
    input  logic [31:0]       cmd_payload_inputs_0,
    input  logic [31:0]       cmd_payload_inputs_1,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_payload_response_ok,
    output logic [DWIDTH-1:0] rsp_payload_outputs_0,
    output logic              arr_we,
    output logic              arr_re,
    output logic [AWIDTH-1:0] arr_addr,
    output logic [PWIDTH-1:0] arr_wdata,
    input  logic [PWIDTH-1:0] arr_rdata,
    output logic              arr_mac_en,
    output logic [ROWS-1:0]   arr_rwl,
    input  logic [SUMW-1:0]   arr_adc_sum
);

    localparam int PLW = (ABITS > 1) ? $clog2(ABITS) : 1;

    state_e            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_ok_q, rsp_ok_d;
    logic [DWIDTH-1:0] rsp_data_q, rsp_data_d;
    logic              arr_we_q, arr_we_d;
    logic              arr_re_q, arr_re_d;
    logic [AWIDTH-1:0] arr_addr_q, arr_addr_d;
    logic [PWIDTH-1:0] arr_wdata_q, arr_wdata_d;
    logic              arr_mac_en_q, arr_mac_en_d;
    logic [ROWS-1:0]   arr_rwl_q, arr_rwl_d;
    logic [DWIDTH-1:0] acc_q, acc_d;
    logic [PLW-1:0]    issue_p_q, issue_p_d;
    logic              ret_vld_q, ret_vld_d;
    logic [PLW-1:0]    ret_shift_q, ret_shift_d;

    opcode_e           opcode;
    logic              fire;
    logic              act_load, act_clr;
    logic [PLW-1:0]    plane_sel;
    logic [ROWS-1:0]   plane_vec;

    // Upper function-id bits and unused address bits carry no meaning here.
    logic unused_cmd_bits;
    assign unused_cmd_bits = ^{cmd_payload_function_id[9:3], cmd_payload_inputs_1};

    pim_act_buf #(
        .ROWS  (ROWS),
        .ABITS (ABITS),
        .PLW   (PLW)
    ) u_act_buf (
        .clk       (clk),
        .reset     (reset),
        .load_en   (act_load),
        .load_grp  (cmd_payload_inputs_1[2:0]),
        .load_data (cmd_payload_inputs_0),
        .clr_en    (act_clr),
        .plane_sel (plane_sel),
        .plane_vec (plane_vec)
    );

    // Plane to present next: plane 0 when a MAC starts, then the successor of
    // the plane currently on the word lines.
    always_comb begin
        plane_sel = '0;
        if (state_q == ST_MAC_RUN) plane_sel = issue_p_q + PLW'(1);
    end

    // Next-state, strobe, accumulator and response logic.
    always_comb begin
        state_d      = state_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_ok_d     = rsp_ok_q;
        rsp_data_d   = rsp_data_q;
        arr_we_d     = 1'b0;
        arr_re_d     = 1'b0;
        arr_addr_d   = '0;
        arr_wdata_d  = '0;
        arr_mac_en_d = 1'b0;
        arr_rwl_d    = '0;
        acc_d        = acc_q;
        issue_p_d    = issue_p_q;
        ret_vld_d    = arr_mac_en_q;
        ret_shift_d  = issue_p_q;
        act_load     = 1'b0;
        act_clr      = 1'b0;
        opcode       = opcode_e'(cmd_payload_function_id[2:0]);
        fire         = cmd_valid && cmd_ready_q;

        // A sum arrives the cycle after its plane was issued; weight by plane.
        if (ret_vld_q) acc_d = acc_q + (DWIDTH'(arr_adc_sum) << ret_shift_q);

        case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    case (opcode)
                        OP_WRITE: begin
                            state_d     = ST_WR;
                            arr_we_d    = 1'b1;
                            arr_addr_d  = cmd_payload_inputs_1[AWIDTH-1:0];
                            arr_wdata_d = PWIDTH'(cmd_payload_inputs_0);
                        end
                        OP_READ: begin
                            state_d    = ST_RD_ISSUE;
                            arr_re_d   = 1'b1;
                            arr_addr_d = cmd_payload_inputs_1[AWIDTH-1:0];
                        end
                        OP_LOAD_ACT, OP_CLEAR_ACT: begin
                            act_load    = (opcode == OP_LOAD_ACT);
                            act_clr     = (opcode == OP_CLEAR_ACT);
                            state_d     = ST_RESP;
                            rsp_valid_d = 1'b1;
                            rsp_ok_d    = 1'b1;
                            rsp_data_d  = '0;
                        end
                        OP_MAC: begin
                            state_d      = ST_MAC_RUN;
                            acc_d        = '0;
                            issue_p_d    = '0;
                            arr_mac_en_d = 1'b1;
                            arr_rwl_d    = plane_vec;
                        end
                        default: begin
                            state_d     = ST_RESP;
                            rsp_valid_d = 1'b1;
                            rsp_ok_d    = 1'b0;
                            rsp_data_d  = '0;
                        end
                    endcase
                end
            end
            ST_WR: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_ok_d    = 1'b1;
                rsp_data_d  = DWIDTH'(arr_wdata_q);
            end
            ST_RD_ISSUE: begin
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_ok_d    = 1'b1;
                rsp_data_d  = DWIDTH'(arr_rdata);
            end
            ST_MAC_RUN: begin
                if (issue_p_q == PLW'(ABITS - 1)) begin
                    state_d = ST_MAC_DRAIN;
                end else begin
                    issue_p_d    = issue_p_q + PLW'(1);
                    arr_mac_en_d = 1'b1;
                    arr_rwl_d    = plane_vec;
                end
            end
            ST_MAC_DRAIN: begin
                // Last plane's sum is folded in this cycle, so report acc_d.
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_ok_d    = 1'b1;
                rsp_data_d  = acc_d;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_ok_d    = 1'b0;
                    rsp_data_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered so that rsp_ready never reaches cmd_ready combinationally.
        cmd_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset aborts everything and zeroes outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_ok_q     <= 1'b0;
            rsp_data_q   <= '0;
            arr_we_q     <= 1'b0;
            arr_re_q     <= 1'b0;
            arr_addr_q   <= '0;
            arr_wdata_q  <= '0;
            arr_mac_en_q <= 1'b0;
            arr_rwl_q    <= '0;
            acc_q        <= '0;
            issue_p_q    <= '0;
            ret_vld_q    <= 1'b0;
            ret_shift_q  <= '0;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_ok_q     <= rsp_ok_d;
            rsp_data_q   <= rsp_data_d;
            arr_we_q     <= arr_we_d;
            arr_re_q     <= arr_re_d;
            arr_addr_q   <= arr_addr_d;
            arr_wdata_q  <= arr_wdata_d;
            arr_mac_en_q <= arr_mac_en_d;
            arr_rwl_q    <= arr_rwl_d;
            acc_q        <= acc_d;
            issue_p_q    <= issue_p_d;
            ret_vld_q    <= ret_vld_d;
            ret_shift_q  <= ret_shift_d;
        end
    end

    assign cmd_ready               = cmd_ready_q;
    assign rsp_valid               = rsp_valid_q;
    assign rsp_payload_response_ok = rsp_ok_q;
    assign rsp_payload_outputs_0   = rsp_data_q;
    assign arr_we                  = arr_we_q;
    assign arr_re                  = arr_re_q;
    assign arr_addr                = arr_addr_q;
    assign arr_wdata               = arr_wdata_q;
    assign arr_mac_en              = arr_mac_en_q;
    assign arr_rwl                 = arr_rwl_q;

endmodule

// File: tb/tb_pim_mac_seq.sv
// Bench for pim_mac_seq: array model, command-level reference model with a
// per-cycle compare process, and directed command sequences.
module tb_pim_mac_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  fid;
    logic [31:0] in0, in1;
    logic        rsp_valid, rsp_ready, rsp_ok;
    logic [31:0] rsp_data;
    logic        arr_we, arr_re, arr_mac_en;
    logic [4:0]  arr_addr;
    logic [31:0] arr_wdata, arr_rdata;
    logic [31:0] arr_rwl;
    logic [10:0] arr_adc_sum;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    int adc_mode = 0;

    // Reference model state
    bit          busy;
    int          we_cyc, re_cyc, mac_start, rsp_cyc;
    logic [4:0]  exp_addr;
    logic [31:0] exp_wdata, exp_data;
    logic        exp_ok;
    logic [31:0] exp_plane [8];
    logic [7:0]  act_m [32];
    logic [31:0] shadow [32];
    logic [31:0] mem [32];

    pim_mac_seq dut (
        .clk                     (clk),
        .reset                   (reset),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (fid),
        .cmd_payload_inputs_0    (in0),
        .cmd_payload_inputs_1    (in1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_response_ok (rsp_ok),
        .rsp_payload_outputs_0   (rsp_data),
        .arr_we                  (arr_we),
        .arr_re                  (arr_re),
        .arr_addr                (arr_addr),
        .arr_wdata               (arr_wdata),
        .arr_rdata               (arr_rdata),
        .arr_mac_en              (arr_mac_en),
        .arr_rwl                 (arr_rwl),
        .arr_adc_sum             (arr_adc_sum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        return {24'hC0FFEE, 8'(i)};
    endfunction

    function automatic logic [10:0] adc_f(input int mode, input logic [31:0] rwl);
        if (mode == 1) return (rwl != 0) ? 11'd5 : 11'd0;
        if (mode == 2) return 11'd1024;
        return 11'($countones(rwl));
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Array model: one-cycle read and ADC latency, junk when not valid.
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
        end else if (arr_we) begin
            mem[arr_addr] <= arr_wdata;
        end
        arr_rdata   <= arr_re ? mem[arr_addr] : $urandom;
        arr_adc_sum <= arr_mac_en ? adc_f(adc_mode, arr_rwl) : 11'($urandom);
    end

    task automatic model_reset();
        busy = 0;
        we_cyc = -100; re_cyc = -100; mac_start = -100; rsp_cyc = -100;
        for (int i = 0; i < 32; i++) begin
            act_m[i] = 8'h00;
            shadow[i] = init_word(i);
        end
    endtask

    // Command-level reference: what the accepted command must produce.
    task automatic model_accept(input int t);
        logic [31:0] acc, pl;
        int g;
        busy = 1;
        exp_ok = 1'b1;
        exp_data = 32'h0;
        rsp_cyc = t + 1;
        case (fid[2:0])
            3'd0: begin
                re_cyc = t + 1; exp_addr = in1[4:0];
                exp_data = shadow[in1[4:0]]; rsp_cyc = t + 3;
            end
            3'd1: begin
                we_cyc = t + 1; exp_addr = in1[4:0]; exp_wdata = in0;
                shadow[in1[4:0]] = in0; exp_data = in0; rsp_cyc = t + 2;
            end
            3'd2: begin
                g = int'(in1[2:0]);
                for (int k = 0; k < 4; k++) act_m[4*g+k] = in0[8*k +: 8];
            end
            3'd3: begin
                acc = 0;
                for (int p = 0; p < 8; p++) begin
                    pl = 0;
                    for (int r = 0; r < 32; r++) pl[r] = act_m[r][p];
                    exp_plane[p] = pl;
                    acc = acc + (32'(adc_f(adc_mode, pl)) << p);
                end
                mac_start = t + 1; exp_data = acc; rsp_cyc = t + 10;
            end
            3'd4: begin
                for (int r = 0; r < 32; r++) act_m[r] = 8'h00;
            end
            default: exp_ok = 1'b0;
        endcase
    endtask

    // Per-cycle comparison against the model, then model update for the edge.
    bit          mac_win, exp_v;
    logic [31:0] want_rwl;
    always @(negedge clk) begin
        if (chk_en) begin
            mac_win = (cyc >= mac_start) && (cyc < mac_start + 8);
            want_rwl = 32'h0;
            if (mac_win) want_rwl = exp_plane[cyc - mac_start];
            check("cmd_ready", cmd_ready, !busy);
            check("arr_we", arr_we, cyc == we_cyc);
            check("arr_re", arr_re, cyc == re_cyc);
            check("arr_mac_en", arr_mac_en, mac_win);
            check("arr_rwl", arr_rwl, want_rwl);
            if (cyc == we_cyc) begin
                check("wr_addr", arr_addr, exp_addr);
                check("wr_data", arr_wdata, exp_wdata);
            end
            if (cyc == re_cyc) check("rd_addr", arr_addr, exp_addr);
            exp_v = busy && (cyc >= rsp_cyc);
            check("rsp_valid", rsp_valid, exp_v);
            if (exp_v) begin
                check("rsp_ok", rsp_ok, exp_ok);
                check("rsp_data", rsp_data, exp_data);
            end
            if (busy) begin
                if (rsp_valid && rsp_ready) busy = 0;
            end else if (cmd_valid && cmd_ready) begin
                model_accept(cyc);
            end
        end
    end

    task automatic issue_only(input logic [2:0] op, input logic [31:0] a0, input logic [31:0] a1,
                              output int t, output bit ok);
        ok = 0; t = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; fid = {7'h2A, op}; in0 = a0; in1 = a1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1; t = cyc; end
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0; fid = 10'($urandom); in0 = $urandom; in1 = $urandom;
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [31:0] a0, input logic [31:0] a1,
                          input int hold, output logic [31:0] rd, output logic rk, output int lat);
        int t;
        bit ok, got;
        rd = 32'hX; rk = 1'bX; lat = -1;
        rsp_ready = (hold == 0);
        issue_only(op, a0, a1, t, ok);
        if (!ok) return;
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                if (i == 5) begin cmd_valid = 1'b1; fid = 10'd1; in0 = 32'h0; in1 = 32'd3; end
                if (i == hold - 3) cmd_valid = 1'b0;
                @(posedge clk); #1;
            end
            rsp_ready = 1'b1;
        end
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid && lat < 0) lat = cyc - t;
            if (rsp_valid && rsp_ready) begin
                got = 1; rd = rsp_data; rk = rsp_ok;
            end
        end
        if (!got) check("rsp_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_strobes"}, {arr_we, arr_re, arr_mac_en, rsp_valid, rsp_ok, cmd_ready}, 6'b0);
        check({tag, "_addr_wdata"}, {arr_addr, arr_wdata}, 37'h0);
        check({tag, "_rwl"}, arr_rwl, 32'h0);
        check({tag, "_rsp_data"}, rsp_data, 32'h0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        #1 check("cmd_ready_before_edge", cmd_ready, 1'b0);
        @(posedge clk); #1;
        check("cmd_ready_first_edge", cmd_ready, 1'b1);
        chk_en = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        k;
        int          lat, t;
        bit          ok;

        reset = 1'b0; cmd_valid = 1'b0; fid = '0; in0 = '0; in1 = '0; rsp_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        release_reset();

        // Write then read back
        do_cmd(3'd1, 32'hDEADBEEF, 32'd3, 0, d, k, lat);
        check("write_latency", lat, 2);
        check("write_echo", d, 32'hDEADBEEF);
        do_cmd(3'd0, 32'h0, 32'd3, 0, d, k, lat);
        check("read_latency", lat, 3);
        check("read_data", d, 32'hDEADBEEF);
        check("read_ok", k, 1'b1);

        // Back-pressure on the response with a stray command while busy
        do_cmd(3'd0, 32'h0, 32'd7, 20, d, k, lat);
        check("held_read_data", d, 32'hC0FFEE07);

        // Two-bit activation on row 0, ADC gives 5 for any active plane
        do_cmd(3'd4, 32'h0, 32'h0, 0, d, k, lat);
        do_cmd(3'd2, 32'h00000003, 32'd0, 0, d, k, lat);
        check("load_latency", lat, 1);
        adc_mode = 1;
        do_cmd(3'd3, 32'h0, 32'h0, 0, d, k, lat);
        check("mac_latency", lat, 10);
        check("mac_small", d, 32'd15);

        // All activations 0xFF, ADC saturating input 1024 every plane
        for (int g = 0; g < 8; g++) do_cmd(3'd2, 32'hFFFFFFFF, 32'(g), 0, d, k, lat);
        adc_mode = 2;
        do_cmd(3'd3, 32'h0, 32'h0, 0, d, k, lat);
        check("mac_full", d, 32'd261120);

        // Sparse pattern with popcount ADC: rows 4..7 one bit each in planes
        // 4..7, row 20 bits 0 and 1 -> 16+32+64+128+1+2
        adc_mode = 0;
        do_cmd(3'd4, 32'h0, 32'h0, 0, d, k, lat);
        do_cmd(3'd2, 32'h80402010, 32'd1, 0, d, k, lat);
        do_cmd(3'd2, 32'h00000003, 32'd5, 0, d, k, lat);
        do_cmd(3'd3, 32'h0, 32'h0, 0, d, k, lat);
        check("mac_sparse", d, 32'd243);

        // All-zero activations still run every plane
        do_cmd(3'd4, 32'h0, 32'h0, 0, d, k, lat);
        do_cmd(3'd3, 32'h0, 32'h0, 0, d, k, lat);
        check("mac_zero", d, 32'd0);
        check("mac_zero_latency", lat, 10);

        // Illegal opcodes
        do_cmd(3'd6, 32'h12345678, 32'h9, 0, d, k, lat);
        check("ill6_ok", k, 1'b0);
        check("ill6_data", d, 32'h0);
        check("ill6_latency", lat, 1);
        do_cmd(3'd5, 32'h1, 32'h1, 0, d, k, lat);
        check("ill5_ok", k, 1'b0);
        do_cmd(3'd7, 32'h1, 32'h1, 0, d, k, lat);
        check("ill7_ok", k, 1'b0);

        // Reset in the middle of a MAC
        do_cmd(3'd2, 32'hFFFFFFFF, 32'd2, 0, d, k, lat);
        issue_only(3'd3, 32'h0, 32'h0, t, ok);
        for (int i = 0; i < 20 && cyc < t + 4; i++) @(negedge clk);
        chk_en = 1'b0;
        reset = 1'b0;
        #1 check_all_zero("midmac_reset");
        model_reset();
        repeat (3) @(posedge clk);
        release_reset();
        repeat (15) @(posedge clk);
        do_cmd(3'd3, 32'h0, 32'h0, 0, d, k, lat);
        check("mac_after_reset", d, 32'd0);
        check("mac_after_reset_ok", k, 1'b1);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
